// File: rtl/switch_event_capture_pkg.sv
// Shared definitions for the switch event capture block: per-switch FSM
// encoding and the long-press parameter sanity check.
package switch_event_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } sec_state_e;

  localparam int LONGPRESS_MIN = 2;

  // The hold counter must be able to represent LONGPRESS-1 without wrapping.
  function automatic bit longpress_ok(input int longpress, input int cnt_width);
    return (longpress >= LONGPRESS_MIN) && (cnt_width < 31) &&
           ((longpress >> cnt_width) == 0);
  endfunction

endpackage

// File: rtl/switch_event_unit.sv
// One switch: press/hold/release FSM, hold counter, previous-level register
// and three sticky write-one-to-clear event flags.
//
//   state      | meaning
//   -----------+------------------------------------------------------
//   ST_IDLE    | switch released, waiting for a rising level
//   ST_PRESSED | switch down, counting towards a long press
//   ST_HELD    | long press already reported, counter frozen
module switch_event_unit
  import switch_event_capture_pkg::*;
#(
  parameter int LONGPRESS = 1000,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic primed,
  input  logic in_switch,
  input  logic ev_clr,
  output logic sw_state,
  output logic ev_press,
  output logic ev_release,
  output logic ev_long,
  output logic flags_any_next
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(LONGPRESS - 1);

  sec_state_e           state;
  sec_state_e           state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 set_press;
  logic                 set_release;
  logic                 set_long;
  logic                 cnt_clr;
  logic                 cnt_inc;
  logic                 press_next;
  logic                 release_next;
  logic                 long_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!primed) begin
      // A switch already down at priming starts counting but is not a press.
      state_next = in_switch ? ST_PRESSED : ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:    if (in_switch && !sw_state) state_next = ST_PRESSED;
        ST_PRESSED: begin
          if (!in_switch)            state_next = ST_IDLE;
          else if (cnt == CNT_LAST)  state_next = ST_HELD;
        end
        ST_HELD:    if (!in_switch) state_next = ST_IDLE;
        default:    state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    set_press   = 1'b0;
    set_release = 1'b0;
    set_long    = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    if (!primed) begin
      cnt_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_switch && !sw_state) begin
            set_press = 1'b1;
            cnt_clr   = 1'b1;
          end
        end
        ST_PRESSED: begin
          if (!in_switch)           set_release = 1'b1;
          else if (cnt == CNT_LAST) set_long    = 1'b1;
          else                      cnt_inc     = 1'b1;
        end
        ST_HELD:  if (!in_switch) set_release = 1'b1;
        default:  cnt_clr = 1'b1;
      endcase
    end
  end

  // A set in the same cycle as a clear wins.
  assign press_next     = set_press   | (ev_press   & ~ev_clr);
  assign release_next   = set_release | (ev_release & ~ev_clr);
  assign long_next      = set_long    | (ev_long    & ~ev_clr);
  assign flags_any_next = press_next | release_next | long_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_state   <= 1'b0;
      cnt        <= '0;
      ev_press   <= 1'b0;
      ev_release <= 1'b0;
      ev_long    <= 1'b0;
    end else begin
      sw_state   <= in_switch;
      ev_press   <= press_next;
      ev_release <= release_next;
      ev_long    <= long_next;
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/switch_event_capture.sv
// Turns debounced switch levels into sticky press/release/long-press flags
// with a masked, registered interrupt.
module switch_event_capture
  import switch_event_capture_pkg::*;
#(
  parameter int SWITCHES  = 5,
  parameter int LONGPRESS = 1000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SWITCHES-1:0] in_switch,
  input  logic [SWITCHES-1:0] ev_clr,
  input  logic [SWITCHES-1:0] irq_en,
  output logic [SWITCHES-1:0] sw_state,
  output logic [SWITCHES-1:0] ev_press,
  output logic [SWITCHES-1:0] ev_release,
  output logic [SWITCHES-1:0] ev_long,
  output logic                irq
);

  if (!longpress_ok(LONGPRESS, CNT_WIDTH)) begin : g_bad_longpress
    $error("switch_event_capture: LONGPRESS out of range for CNT_WIDTH");
  end

  logic                primed;
  logic [SWITCHES-1:0] flags_any_next;

  // First edge out of reset only samples levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) primed <= 1'b0;
    else     primed <= 1'b1;
  end

  switch_event_unit #(
    .LONGPRESS (LONGPRESS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_unit [SWITCHES-1:0] (
    .clk            (clk),
    .rst            (rst),
    .primed         (primed),
    .in_switch      (in_switch),
    .ev_clr         (ev_clr),
    .sw_state       (sw_state),
    .ev_press       (ev_press),
    .ev_release     (ev_release),
    .ev_long        (ev_long),
    .flags_any_next (flags_any_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq <= 1'b0;
    else     irq <= |(irq_en & flags_any_next);
  end

endmodule

// File: tb/tb_switch_event_capture.sv
// Randomised and directed bench for switch_event_capture against a
// cycle-counting reference model of the event rules.
module tb_switch_event_capture;

  localparam int SW = 5;
  localparam int LP = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] in_switch;
  logic [SW-1:0] ev_clr;
  logic [SW-1:0] irq_en;
  logic [SW-1:0] sw_state;
  logic [SW-1:0] ev_press;
  logic [SW-1:0] ev_release;
  logic [SW-1:0] ev_long;
  logic          irq;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  bit [SW-1:0] m_prev;
  bit [SW-1:0] m_press;
  bit [SW-1:0] m_rel;
  bit [SW-1:0] m_long;
  bit          m_irq;
  bit          m_primed;
  int          m_hold [SW];

  switch_event_capture #(
    .SWITCHES  (SW),
    .LONGPRESS (LP),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_switch  (in_switch),
    .ev_clr     (ev_clr),
    .irq_en     (irq_en),
    .sw_state   (sw_state),
    .ev_press   (ev_press),
    .ev_release (ev_release),
    .ev_long    (ev_long),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("sw_state",   32'(sw_state),   32'(m_prev));
    check("ev_press",   32'(ev_press),   32'(m_press));
    check("ev_release", 32'(ev_release), 32'(m_rel));
    check("ev_long",    32'(ev_long),    32'(m_long));
    check("irq",        32'(irq),        32'(m_irq));
  endtask

  task automatic model_reset();
    m_prev   = '0;
    m_press  = '0;
    m_rel    = '0;
    m_long   = '0;
    m_irq    = 1'b0;
    m_primed = 1'b0;
    for (int i = 0; i < SW; i++) m_hold[i] = 0;
  endtask

  // Assert reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
  endtask

  // One clock edge: advance the model from the inputs seen at the edge,
  // then compare shortly after the edge.
  task automatic step();
    bit [SW-1:0] sp, sr, sl;
    @(posedge clk);
    sp = '0; sr = '0; sl = '0;
    if (!rst) begin
      if (!m_primed) begin
        m_primed = 1'b1;
        for (int i = 0; i < SW; i++) m_hold[i] = 0;
      end else begin
        for (int i = 0; i < SW; i++) begin
          if (in_switch[i] && !m_prev[i]) begin
            sp[i] = 1'b1;
            m_hold[i] = 0;
          end else if (in_switch[i] && m_prev[i]) begin
            m_hold[i]++;
            if (m_hold[i] == LP) sl[i] = 1'b1;
          end else if (!in_switch[i] && m_prev[i]) begin
            sr[i] = 1'b1;
          end
        end
      end
      m_prev  = in_switch;
      m_press = (m_press & ~ev_clr) | sp;
      m_rel   = (m_rel   & ~ev_clr) | sr;
      m_long  = (m_long  & ~ev_clr) | sl;
      m_irq   = |(irq_en & (m_press | m_rel | m_long));
    end
    #1;
    check_all();
  endtask

  initial begin
    in_switch = 5'b00001;
    ev_clr    = '0;
    irq_en    = '0;
    rst       = 1'b0;
    do_reset();
    check("reset_flags", 32'(ev_press | ev_release | ev_long), 32'd0);
    repeat (2) step();
    @(negedge clk) rst = 1'b0;

    // Priming with bit 0 already high
    step();
    check("prime_sw_state", 32'(sw_state), 32'd1);
    check("prime_no_press", 32'(ev_press), 32'd0);
    repeat (LP) step();
    check("prime_long", 32'(ev_long[0]), 32'd1);

    irq_en = 5'b11111;
    ev_clr = 5'b11111; step(); ev_clr = '0;
    step();

    // Press/release on switch 2
    in_switch[2] = 1'b1;
    step();
    check("press2_flag", 32'(ev_press[2]), 32'd1);
    check("press2_irq",  32'(irq), 32'd1);
    repeat (2) step();
    in_switch[2] = 1'b0;
    step();
    check("rel2_flag", 32'(ev_release[2]), 32'd1);
    check("rel2_nolong", 32'(ev_long[2]), 32'd0);

    // Long press on switch 4
    in_switch[4] = 1'b1;
    repeat (20) step();
    in_switch[4] = 1'b0;
    step();
    check("long4_flag", 32'(ev_long[4]), 32'd1);

    // Clear bit 2, then clear colliding with a new press
    ev_clr = 5'b00100; step(); ev_clr = '0;
    check("clr2_bits", 32'({ev_press[2], ev_release[2], ev_long[2]}), 32'd0);
    step();
    in_switch[2] = 1'b1;
    ev_clr = 5'b00100; step(); ev_clr = '0;
    check("clr_vs_press", 32'(ev_press[2]), 32'd1);
    in_switch[2] = 1'b0;
    step();

    // Masked interrupt on switch 1
    ev_clr = 5'b11111; step(); ev_clr = '0;
    in_switch[0] = 1'b0; step();
    ev_clr = 5'b11111; step(); ev_clr = '0;
    irq_en = '0;
    in_switch[1] = 1'b1;
    repeat (2) step();
    check("mask_press", 32'(ev_press[1]), 32'd1);
    check("mask_irq", 32'(irq), 32'd0);
    irq_en = 5'b00010;
    step();
    check("unmask_irq", 32'(irq), 32'd1);
    in_switch[1] = 1'b0;
    step();

    // Reset four cycles into a press on switch 3
    in_switch[3] = 1'b1;
    repeat (4) step();
    do_reset();
    repeat (2) step();
    @(negedge clk) rst = 1'b0;
    repeat (LP + 2) step();
    in_switch[3] = 1'b0;
    step();

    // Random traffic
    irq_en = 5'b11111;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < SW; i++)
        if ($urandom_range(0, 9) == 0) in_switch[i] = ~in_switch[i];
      ev_clr = ($urandom_range(0, 3) == 0) ? SW'($urandom) : '0;
      if ($urandom_range(0, 19) == 0) irq_en = SW'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        step();
        @(negedge clk) rst = 1'b0;
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
